// File: rtl/rhythm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rhythm_pkg: sound-command and FSM enums, note ROM and half-period helper.
// Rev 1.0
// ----------------------------------------------------------------------------
package rhythm_pkg;

  typedef enum logic [1:0] {
    SND_NONE = 2'd0,
    SND_HIT  = 2'd1,
    SND_MISS = 2'd2,
    SND_OVER = 2'd3
  } snd_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TONE = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int unsigned F_HIT    = 1047;
  localparam int unsigned F_MISS_0 = 330;
  localparam int unsigned F_MISS_1 = 262;
  localparam int unsigned F_OVER_0 = 523;
  localparam int unsigned F_OVER_1 = 392;
  localparam int unsigned F_OVER_2 = 262;

  localparam int NOTE_ROM_SIZE = 6;

  // Sequences are packed back to back: hit at 0, miss at 1..2, game-over at 3..5.
  localparam int unsigned NOTE_ROM [0:NOTE_ROM_SIZE-1] = '{
    F_HIT, F_MISS_0, F_MISS_1, F_OVER_0, F_OVER_1, F_OVER_2
  };

  function automatic logic [2:0] rom_base(input snd_cmd_e cmd);
    case (cmd)
      SND_HIT:  return 3'd0;
      SND_MISS: return 3'd1;
      SND_OVER: return 3'd3;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] note_count(input snd_cmd_e cmd);
    case (cmd)
      SND_HIT:  return 2'd1;
      SND_MISS: return 2'd2;
      SND_OVER: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  function automatic logic [23:0] half_period(input int unsigned clk_hz, input int unsigned freq);
    return 24'(clk_hz / (2 * freq));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sound_cmd_fifo: synchronous FIFO; flush has priority over push and pop.
// Rev 1.0
// ----------------------------------------------------------------------------
module sound_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/piezo_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piezo_sequencer: queues sound commands and plays them as square-wave notes.
// PIEZO_SEQ_PREEMPT_EN: game-over flushes the queue and aborts playback. Rev 1.0
// ----------------------------------------------------------------------------
module piezo_sequencer
  import rhythm_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NOTE_MS    = 60,
  parameter int unsigned GAP_MS     = 10
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic [1:0]                  i_Sound_Cmd,
  input  logic                        i_Mute,
  output logic                        o_Piezo,
  output logic                        o_Busy,
  output logic                        o_Drop,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Cnt
);
  localparam logic [31:0] NOTE_LAST = 32'(CLK_HZ / 1000 * NOTE_MS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(CLK_HZ / 1000 * GAP_MS - 1);
  localparam logic [23:0] HP_TABLE [0:NOTE_ROM_SIZE-1] = '{
    half_period(CLK_HZ, NOTE_ROM[0]), half_period(CLK_HZ, NOTE_ROM[1]),
    half_period(CLK_HZ, NOTE_ROM[2]), half_period(CLK_HZ, NOTE_ROM[3]),
    half_period(CLK_HZ, NOTE_ROM[4]), half_period(CLK_HZ, NOTE_ROM[5])
  };

  logic [1:0]  cmd_prev;
  logic        capture;
  logic        preempt;
  logic        push;
  logic        pop;
  logic        drop;
  logic        drop_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic [1:0]  fifo_dout;
  seq_state_e  state;
  snd_cmd_e    seq;
  logic [1:0]  note_idx;
  logic [2:0]  rom_idx;
  logic [23:0] half_per;
  logic [23:0] half_cnt;
  logic [31:0] phase_cnt;
  logic        wave;

  // Edge-style capture: a held level yields one event, any change to a non-zero code is new.
  assign capture = (i_Sound_Cmd != SND_NONE) && (i_Sound_Cmd != cmd_prev);

`ifdef PIEZO_SEQ_PREEMPT_EN
  assign preempt = capture && (i_Sound_Cmd == SND_OVER);
`else
  assign preempt = 1'b0;
`endif

  assign push    = capture && !preempt && !fifo_full;
  assign drop    = capture && !preempt && fifo_full;
  assign pop     = (state == ST_IDLE) && !fifo_empty && !preempt;
  assign rom_idx = rom_base(seq) + {1'b0, note_idx};

  sound_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .push  (push),
    .pop   (pop),
    .flush (preempt),
    .din   (i_Sound_Cmd),
    .dout  (fifo_dout),
    .count (o_Fifo_Cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cmd_prev  <= 2'd0;
      drop_q    <= 1'b0;
      state     <= ST_IDLE;
      seq       <= SND_NONE;
      note_idx  <= 2'd0;
      half_per  <= 24'd0;
      half_cnt  <= 24'd0;
      phase_cnt <= 32'd0;
      wave      <= 1'b0;
    end else begin
      cmd_prev <= i_Sound_Cmd;
      drop_q   <= drop;
      if (preempt) begin
        state    <= ST_LOAD;
        seq      <= SND_OVER;
        note_idx <= 2'd0;
        wave     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty) begin
              seq      <= snd_cmd_e'(fifo_dout);
              note_idx <= 2'd0;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            half_per  <= HP_TABLE[rom_idx];
            half_cnt  <= 24'd0;
            phase_cnt <= 32'd0;
            wave      <= 1'b1;
            state     <= ST_TONE;
          end
          ST_TONE: begin
            if (phase_cnt >= NOTE_LAST) begin
              phase_cnt <= 32'd0;
              wave      <= 1'b0;
              state     <= ST_GAP;
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
              if (half_cnt >= half_per - 24'd1) begin
                half_cnt <= 24'd0;
                wave     <= ~wave;
              end else begin
                half_cnt <= half_cnt + 24'd1;
              end
            end
          end
          default: begin
            if (phase_cnt >= GAP_LAST) begin
              if (({1'b0, note_idx} + 3'd1) < {1'b0, note_count(seq)}) begin
                note_idx <= note_idx + 2'd1;
                state    <= ST_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              phase_cnt <= phase_cnt + 32'd1;
            end
          end
        endcase
      end
    end
  end

  assign o_Piezo = wave && !i_Mute;
  assign o_Busy  = (state != ST_IDLE);
  assign o_Drop  = drop_q;

endmodule
`default_nettype wire
